// File: rtl/fir_pkg.sv
// Shared constants, types and helpers for the time-multiplexed FIR engine.
package fir_pkg;
  localparam int ORDER  = 8;
  localparam int N_TAPS = ORDER + 1;
  localparam int W_IN   = 8;
  localparam int W_OUT  = 2 * W_IN + 2;

  // Width of a tap index covering 0..n-1.
  function automatic int tap_idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int IDX_W = tap_idx_w(N_TAPS);

  typedef logic [N_TAPS-1:0][W_IN-1:0] word_vec_t;

  // b8..b0, most significant entry first; b0 lands at index 0.
  localparam word_vec_t COEF_INIT = {8'h00, 8'h00, 8'h0C, 8'h88, 8'hEC,
                                     8'h88, 8'h0C, 8'h00, 8'h00};

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_DONE} state_t;
endpackage

// File: rtl/fir_tap_mac.sv
// Shared multiply-accumulate unit: acc + coef*tap, accumulator with clear/enable.
module fir_tap_mac
  import fir_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [W_IN-1:0]  coef,
  input  logic [W_IN-1:0]  tap,
  output logic [W_OUT-1:0] acc,
  output logic [W_OUT-1:0] sum
);
  logic [2*W_IN-1:0] prod;

  assign prod = coef * tap;
  // Unsigned product zero-extended; the add wraps modulo 2^W_OUT.
  assign sum  = acc + W_OUT'(prod);

  // Accumulator: clear on a new sample, accumulate while sequencing taps.
  always_ff @(posedge clock) begin
    if (reset || clr) acc <= '0;
    else if (en)      acc <= sum;
  end
endmodule

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR: one MAC sequenced over ORDER+1 taps per accepted sample.
module fir_mac_sequencer
  import fir_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic [W_IN-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [W_OUT-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             coef_we,
  input  logic [IDX_W-1:0] coef_addr,
  input  logic [W_IN-1:0]  coef_wdata,
  output logic             busy
);
  state_t           state;
  logic [IDX_W-1:0] idx;
  word_vec_t        taps;
  word_vec_t        coef_q;
  logic             accept;
  logic             mac_en;
  logic             mac_last;
  logic [W_OUT-1:0] acc;
  logic [W_OUT-1:0] sum;

  // A new sample can enter when idle, or when the held result leaves this cycle.
  assign in_ready = !reset && ((state == S_IDLE) || (state == S_DONE && out_ready));
  assign accept   = in_valid && in_ready;
  assign mac_en   = (state == S_MAC);
  assign mac_last = mac_en && (idx == IDX_W'(ORDER));
  assign busy     = (state != S_IDLE);

  fir_tap_mac u_mac (
    .clock (clock),
    .reset (reset),
    .clr   (accept),
    .en    (mac_en),
    .coef  (coef_q[idx]),
    .tap   (taps[idx]),
    .acc   (acc),
    .sum   (sum)
  );

  // Delay line: shifts only on an accepted sample, newest at index 0.
  always_ff @(posedge clock) begin
    if (reset)       taps <= '0;
    else if (accept) taps <= {taps[ORDER-1:0], in_data};
  end

  // Coefficient file: writable only while idle, out-of-range addresses dropped.
  always_ff @(posedge clock) begin
    if (reset)
      coef_q <= COEF_INIT;
    else if (coef_we && state == S_IDLE && coef_addr <= IDX_W'(ORDER))
      coef_q[coef_addr] <= coef_wdata;
  end

  // Sequencer FSM with registered result and valid.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      idx       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          idx <= '0;
          if (accept) state <= S_MAC;
        end
        S_MAC: begin
          idx <= idx + 1'b1;
          if (mac_last) begin
            out_data  <= sum;
            out_valid <= 1'b1;
            idx       <= '0;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          idx <= '0;
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= accept ? S_MAC : S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
